// File: rtl/uart_rx_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uart_ctrl_pkg                                          |
// | Brief   : Shared types for the UART receive controller: frame    |
// |           encodings, configuration record and block FSM states.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package uart_ctrl_pkg;

   // Width of the prescale and timeout fields held in the config record
   localparam int CFG_CNT_W = 16;

   // Data-bit encoding as seen by uart_rx
   typedef enum logic [1:0] {
      DB_8 = 2'b00,
      DB_7 = 2'b01,
      DB_6 = 2'b10,
      DB_5 = 2'b11
   } data_bits_e;

   // Stop-bit encoding as seen by uart_rx
   typedef enum logic [1:0] {
      SB_1   = 2'b00,
      SB_1P5 = 2'b01,
      SB_2   = 2'b10
   } stop_bits_e;

   typedef struct packed {
      data_bits_e             data_bits;
      stop_bits_e             stop_bits;
      logic                   parity_en;
      logic                   parity_type;
      logic [CFG_CNT_W-1:0]   prescale;
      logic [CFG_CNT_W-1:0]   timeout;
   } uart_cfg_t;

   // Block assembly states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_OUT  = 2'd2
   } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : taxi_axis_if                                           |
// | Brief   : Minimal AXI-Stream bundle (tdata/tvalid/tready) with   |
// |           source and sink modports.                              |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface taxi_axis_if #(
   parameter int DATA_W = 8
) ();
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;

   modport src (output tdata, output tvalid, input tready);
   modport snk (input tdata, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/uart_rx_ctrl_baud_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uart_baud_gen                                          |
// | Brief   : Prescale down-counter producing a one-cycle baud tick  |
// |           every prescale+1 cycles; load restarts the period so   |
// |           the next tick lands on the following cycle.            |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module uart_baud_gen #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] prescale,
   output logic             baud_clk
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   // Next count: a load behaves as if the counter were already at zero
   always_comb begin
      cnt_d  = cnt_q - CNT_W'(1);
      tick_d = 1'b0;
      if (load || (cnt_q == '0)) begin
         cnt_d  = prescale;
         tick_d = 1'b1;
      end
   end

   // Counter and registered tick
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign baud_clk = tick_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uart_rx_ctrl                                           |
// | Brief   : Baud tick generation, between-frame config apply,      |
// |           byte-to-AES-block packing with error/timeout discard   |
// |           and sticky error status for the UART receive path.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module uart_rx_ctrl
   import uart_ctrl_pkg::*;
#(
   parameter int PRESCALE_W = 16,
   parameter int BLK_BYTES  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [PRESCALE_W-1:0] cfg_prescale,
   input  logic [1:0]            cfg_data_bits,
   input  logic [1:0]            cfg_stop_bits,
   input  logic                  cfg_parity_en,
   input  logic                  cfg_parity_type,
   input  logic [PRESCALE_W-1:0] cfg_timeout,
   input  logic                  cfg_apply,
   output logic                  cfg_pending,
   output logic                  baud_clk,
   output logic [1:0]            rx_data_bits,
   output logic [1:0]            rx_stop_bits,
   output logic                  rx_parity_en,
   output logic                  rx_parity_type,
   input  logic                  rx_busy,
   input  logic                  rx_overrun_err,
   input  logic                  rx_frame_err,
   input  logic                  rx_parity_err,
   taxi_axis_if.snk              s_axis_rx,
   taxi_axis_if.src              m_axis_blk,
   output logic                  blk_drop,
   output logic                  sts_overrun,
   output logic                  sts_frame,
   output logic                  sts_parity,
   output logic                  sts_timeout,
   input  logic                  sts_clear
);

   localparam int BLK_W = 8 * BLK_BYTES;
   localparam int CNT_W = $clog2(BLK_BYTES + 1);
   localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLK_BYTES - 1);
   localparam uart_cfg_t CFG_RESET = '{
      data_bits:   DB_8,
      stop_bits:   SB_1,
      parity_en:   1'b0,
      parity_type: 1'b0,
      prescale:    '0,
      timeout:     '0
   };

   uart_cfg_t              cfg_in;
   uart_cfg_t              shadow_q, shadow_d;
   uart_cfg_t              active_q, active_d;
   logic                   pending_q, pending_d;
   rx_state_t              state_q, state_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [BLK_W-1:0]       tdata_q, tdata_d;
   logic                   tvalid_q, tvalid_d;
   logic                   drop_q, drop_d;
   logic [CFG_CNT_W-1:0]   idle_q, idle_d;
   logic                   sts_overrun_q, sts_overrun_d;
   logic                   sts_frame_q, sts_frame_d;
   logic                   sts_parity_q, sts_parity_d;
   logic                   sts_timeout_q, sts_timeout_d;

   logic                   w_baud;
   logic                   w_hs;
   logic                   w_out_hs;
   logic                   w_line_err;
   logic                   w_apply_now;
   logic                   w_expire;

   assign w_hs       = s_axis_rx.tvalid && (state_q != ST_OUT);
   assign w_out_hs   = tvalid_q && m_axis_blk.tready;
   assign w_line_err = rx_frame_err || rx_parity_err;

   // Timeout fires on the tick that brings the idle count to the limit,
   // unless a byte lands in the same cycle
   assign w_expire = (state_q == ST_FILL) && (active_q.timeout != '0) && w_baud
                     && !w_hs && ((idle_q + CFG_CNT_W'(1)) == active_q.timeout);

   // Shadow capture and between-frame copy to the active config
   always_comb begin
      cfg_in             = CFG_RESET;
      cfg_in.data_bits   = data_bits_e'(cfg_data_bits);
      cfg_in.stop_bits   = stop_bits_e'(cfg_stop_bits);
      cfg_in.parity_en   = cfg_parity_en;
      cfg_in.parity_type = cfg_parity_type;
      cfg_in.prescale    = CFG_CNT_W'(cfg_prescale);
      cfg_in.timeout     = CFG_CNT_W'(cfg_timeout);

      w_apply_now = (pending_q || cfg_apply) && !rx_busy
                    && (state_q == ST_IDLE) && (count_q == '0);
      shadow_d    = cfg_apply ? cfg_in : shadow_q;
      active_d    = w_apply_now ? shadow_d : active_q;
      pending_d   = (pending_q || cfg_apply) && !w_apply_now;
   end

   uart_baud_gen #(
      .CNT_W (CFG_CNT_W)
   ) u_baud_gen (
      .clk      (clk),
      .rst      (rst),
      .load     (w_apply_now),
      .prescale (active_d.prescale),
      .baud_clk (w_baud)
   );

   // Block FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (!w_line_err && w_hs) state_d = ST_FILL;
         ST_FILL: begin
            if (w_line_err || w_expire)          state_d = ST_IDLE;
            else if (w_hs && count_q == BLK_LAST) state_d = ST_OUT;
         end
         ST_OUT:  if (w_out_hs) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Byte packing, counters, drop pulse and sticky flags
   always_comb begin
      count_d  = count_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      drop_d   = 1'b0;
      idle_d   = idle_q;

      // Shift-in keeps the first byte of a block in the top lane
      if (w_hs) tdata_d = {tdata_q[BLK_W-9:0], s_axis_rx.tdata[7:0]};

      unique case (state_q)
         ST_IDLE: begin
            idle_d = '0;
            if (w_line_err) begin
               count_d = '0;
               drop_d  = w_hs;
            end else if (w_hs) begin
               count_d = CNT_W'(1);
            end
         end
         ST_FILL: begin
            if (w_line_err || w_expire) begin
               count_d = '0;
               drop_d  = 1'b1;
               idle_d  = '0;
            end else if (w_hs) begin
               count_d = count_q + CNT_W'(1);
               idle_d  = '0;
               if (count_q == BLK_LAST) tvalid_d = 1'b1;
            end else if ((active_q.timeout != '0) && w_baud) begin
               idle_d = idle_q + CFG_CNT_W'(1);
            end
         end
         ST_OUT: begin
            idle_d = '0;
            if (w_out_hs) begin
               tvalid_d = 1'b0;
               count_d  = '0;
            end
         end
         default: begin
            count_d = '0;
            idle_d  = '0;
         end
      endcase

      // An event in the same cycle as a clear keeps the flag set
      sts_overrun_d = (sts_overrun_q && !sts_clear) || rx_overrun_err;
      sts_frame_d   = (sts_frame_q   && !sts_clear) || rx_frame_err;
      sts_parity_d  = (sts_parity_q  && !sts_clear) || rx_parity_err;
      sts_timeout_d = (sts_timeout_q && !sts_clear) || w_expire;
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q      <= CFG_RESET;
         active_q      <= CFG_RESET;
         pending_q     <= 1'b0;
         state_q       <= ST_IDLE;
         count_q       <= '0;
         tdata_q       <= '0;
         tvalid_q      <= 1'b0;
         drop_q        <= 1'b0;
         idle_q        <= '0;
         sts_overrun_q <= 1'b0;
         sts_frame_q   <= 1'b0;
         sts_parity_q  <= 1'b0;
         sts_timeout_q <= 1'b0;
      end else begin
         shadow_q      <= shadow_d;
         active_q      <= active_d;
         pending_q     <= pending_d;
         state_q       <= state_d;
         count_q       <= count_d;
         tdata_q       <= tdata_d;
         tvalid_q      <= tvalid_d;
         drop_q        <= drop_d;
         idle_q        <= idle_d;
         sts_overrun_q <= sts_overrun_d;
         sts_frame_q   <= sts_frame_d;
         sts_parity_q  <= sts_parity_d;
         sts_timeout_q <= sts_timeout_d;
      end
   end

   // Stream handshake outputs derived from state and held block
   always_comb begin
      s_axis_rx.tready  = (state_q != ST_OUT);
      m_axis_blk.tvalid = tvalid_q;
      m_axis_blk.tdata  = tdata_q;
   end

   assign cfg_pending    = pending_q;
   assign baud_clk       = w_baud;
   assign rx_data_bits   = active_q.data_bits;
   assign rx_stop_bits   = active_q.stop_bits;
   assign rx_parity_en   = active_q.parity_en;
   assign rx_parity_type = active_q.parity_type;
   assign blk_drop       = drop_q;
   assign sts_overrun    = sts_overrun_q;
   assign sts_frame      = sts_frame_q;
   assign sts_parity     = sts_parity_q;
   assign sts_timeout    = sts_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_uart_rx_ctrl                                        |
// | Brief   : Directed self-checking bench for uart_rx_ctrl.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_uart_rx_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cfg_prescale;
   logic [1:0]  cfg_data_bits;
   logic [1:0]  cfg_stop_bits;
   logic        cfg_parity_en;
   logic        cfg_parity_type;
   logic [15:0] cfg_timeout;
   logic        cfg_apply;
   logic        cfg_pending;
   logic        baud_clk;
   logic [1:0]  rx_data_bits;
   logic [1:0]  rx_stop_bits;
   logic        rx_parity_en;
   logic        rx_parity_type;
   logic        rx_busy;
   logic        rx_overrun_err;
   logic        rx_frame_err;
   logic        rx_parity_err;
   logic        blk_drop;
   logic        sts_overrun;
   logic        sts_frame;
   logic        sts_parity;
   logic        sts_timeout;
   logic        sts_clear;

   int total = 0;
   int bad   = 0;
   int drop_cnt = 0;

   taxi_axis_if #(.DATA_W(8))   s_if ();
   taxi_axis_if #(.DATA_W(128)) m_if ();

   uart_rx_ctrl #(
      .PRESCALE_W (16),
      .BLK_BYTES  (16)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .cfg_prescale    (cfg_prescale),
      .cfg_data_bits   (cfg_data_bits),
      .cfg_stop_bits   (cfg_stop_bits),
      .cfg_parity_en   (cfg_parity_en),
      .cfg_parity_type (cfg_parity_type),
      .cfg_timeout     (cfg_timeout),
      .cfg_apply       (cfg_apply),
      .cfg_pending     (cfg_pending),
      .baud_clk        (baud_clk),
      .rx_data_bits    (rx_data_bits),
      .rx_stop_bits    (rx_stop_bits),
      .rx_parity_en    (rx_parity_en),
      .rx_parity_type  (rx_parity_type),
      .rx_busy         (rx_busy),
      .rx_overrun_err  (rx_overrun_err),
      .rx_frame_err    (rx_frame_err),
      .rx_parity_err   (rx_parity_err),
      .s_axis_rx       (s_if),
      .m_axis_blk      (m_if),
      .blk_drop        (blk_drop),
      .sts_overrun     (sts_overrun),
      .sts_frame       (sts_frame),
      .sts_parity      (sts_parity),
      .sts_timeout     (sts_timeout),
      .sts_clear       (sts_clear)
   );

   always #5 clk = ~clk;

   // Count drop pulses away from the active edge
   always @(negedge clk) begin
      if (!rst && blk_drop) drop_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         s_if.tvalid = 1'b1;
         s_if.tdata  = first + 8'(i);
         tick();
      end
      s_if.tvalid = 1'b0;
   endtask

   task automatic apply_cfg(input logic [15:0] pre, input logic [1:0] db,
                            input logic pen, input logic [15:0] tmo);
      cfg_prescale  = pre;
      cfg_data_bits = db;
      cfg_parity_en = pen;
      cfg_timeout   = tmo;
      cfg_apply     = 1'b1;
      tick();
      cfg_apply     = 1'b0;
   endtask

   initial begin
      int ticks;
      int drops_before;

      rst = 1'b1;
      cfg_prescale = '0; cfg_data_bits = '0; cfg_stop_bits = '0;
      cfg_parity_en = 1'b0; cfg_parity_type = 1'b0; cfg_timeout = '0;
      cfg_apply = 1'b0; rx_busy = 1'b0; rx_overrun_err = 1'b0;
      rx_frame_err = 1'b0; rx_parity_err = 1'b0; sts_clear = 1'b0;
      s_if.tvalid = 1'b0; s_if.tdata = '0; m_if.tready = 1'b1;
      repeat (3) tick();

      // Reset state
      check("rst_baud", baud_clk, 0);
      check("rst_pending", cfg_pending, 0);
      check("rst_s_tready", s_if.tready, 1);
      check("rst_m_tvalid", m_if.tvalid, 0);
      check("rst_m_tdata", m_if.tdata, 0);
      check("rst_drop", blk_drop, 0);
      check("rst_sts", {sts_overrun, sts_frame, sts_parity, sts_timeout}, 0);
      check("rst_cfg", {rx_data_bits, rx_stop_bits, rx_parity_en, rx_parity_type}, 0);
      rst = 1'b0;
      tick();

      // Baud generator: prescale 3 gives one tick in four, first right after apply
      apply_cfg(16'd3, 2'b00, 1'b0, 16'd0);
      check("baud_first", baud_clk, 1);
      check("baud_pend_clr", cfg_pending, 0);
      for (int i = 1; i <= 8; i++) begin
         tick();
         check("baud_p3", baud_clk, (i % 4 == 0));
      end
      apply_cfg(16'd0, 2'b00, 1'b0, 16'd0);
      for (int i = 0; i < 5; i++) begin
         check("baud_p0", baud_clk, 1);
         tick();
      end

      // Clean block 0x00..0x0F
      drops_before = drop_cnt;
      send(8'h00, 16);
      check("blk0_tvalid", m_if.tvalid, 1);
      check("blk0_tdata", m_if.tdata, 128'h000102030405060708090A0B0C0D0E0F);
      check("blk0_s_tready", s_if.tready, 0);
      tick();
      check("blk0_done_tvalid", m_if.tvalid, 0);
      check("blk0_done_s_tready", s_if.tready, 1);
      check("blk0_no_drop", drop_cnt, drops_before);

      // Backpressure: block held while downstream stalls, extra bytes refused
      m_if.tready = 1'b0;
      send(8'hA0, 16);
      s_if.tvalid = 1'b1;
      s_if.tdata  = 8'hFF;
      for (int i = 0; i < 50; i++) begin
         check("bp_tvalid", m_if.tvalid, 1);
         check("bp_tdata", m_if.tdata, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
         check("bp_s_tready", s_if.tready, 0);
         tick();
      end
      s_if.tvalid = 1'b0;
      m_if.tready = 1'b1;
      tick();
      check("bp_release_tvalid", m_if.tvalid, 0);
      check("bp_release_s_tready", s_if.tready, 1);

      // Parity error mid-block discards it
      drops_before = drop_cnt;
      send(8'h50, 5);
      rx_parity_err = 1'b1;
      tick();
      rx_parity_err = 1'b0;
      check("par_drop", blk_drop, 1);
      check("par_sticky", sts_parity, 1);
      tick();
      check("par_drop_one", blk_drop, 0);
      send(8'h10, 16);
      check("par_next_tvalid", m_if.tvalid, 1);
      check("par_next_tdata", m_if.tdata, 128'h101112131415161718191A1B1C1D1E1F);
      tick();
      check("par_drop_count", drop_cnt, drops_before + 1);
      sts_clear = 1'b1;
      tick();
      sts_clear = 1'b0;
      check("par_clear", sts_parity, 0);

      // Overrun set coincides with clear: set wins
      rx_overrun_err = 1'b1;
      sts_clear = 1'b1;
      tick();
      rx_overrun_err = 1'b0;
      sts_clear = 1'b0;
      check("ovr_set_wins", sts_overrun, 1);
      sts_clear = 1'b1;
      tick();
      sts_clear = 1'b0;
      check("ovr_cleared", sts_overrun, 0);

      // Frame error while a block is held only sets the flag
      drops_before = drop_cnt;
      m_if.tready = 1'b0;
      send(8'h30, 16);
      rx_frame_err = 1'b1;
      tick();
      rx_frame_err = 1'b0;
      check("out_frame_sticky", sts_frame, 1);
      check("out_frame_tvalid", m_if.tvalid, 1);
      check("out_frame_tdata", m_if.tdata, 128'h303132333435363738393A3B3C3D3E3F);
      check("out_frame_no_drop", drop_cnt, drops_before);
      m_if.tready = 1'b1;
      tick();
      check("out_frame_done", m_if.tvalid, 0);

      // Inter-byte timeout of 20 baud ticks at prescale 3
      apply_cfg(16'd3, 2'b00, 1'b0, 16'd20);
      drops_before = drop_cnt;
      send(8'h60, 3);
      ticks = 0;
      for (int i = 0; i < 500 && !blk_drop; i++) begin
         if (baud_clk) ticks++;
         tick();
      end
      check("tmo_seen", blk_drop, 1);
      check("tmo_ticks", ticks, 20);
      check("tmo_sticky", sts_timeout, 1);
      check("tmo_idle", s_if.tready, 1);
      tick();
      check("tmo_drop_count", drop_cnt, drops_before + 1);

      // Timeout disabled: no drop after 1000 ticks
      apply_cfg(16'd3, 2'b00, 1'b0, 16'd0);
      drops_before = drop_cnt;
      send(8'h70, 3);
      ticks = 0;
      for (int i = 0; i < 5000 && ticks < 1000; i++) begin
         if (baud_clk) ticks++;
         tick();
      end
      check("notmo_ticks", ticks, 1000);
      check("notmo_no_drop", drop_cnt, drops_before);
      send(8'h73, 13);
      check("notmo_tdata", m_if.tdata, 128'h707172737475767778797A7B7C7D7E7F);
      tick();
      sts_clear = 1'b1;
      tick();
      sts_clear = 1'b0;

      // Config apply deferred while receiving, taken once idle and not busy
      send(8'h20, 5);
      rx_busy = 1'b1;
      cfg_parity_type = 1'b0;
      apply_cfg(16'd3, 2'b01, 1'b1, 16'd0);
      check("pend_set", cfg_pending, 1);
      check("pend_old_bits", rx_data_bits, 2'b00);
      check("pend_old_par", rx_parity_en, 0);
      send(8'h25, 11);
      check("pend_blk_tdata", m_if.tdata, 128'h202122232425262728292A2B2C2D2E2F);
      tick();
      check("pend_blk_done", m_if.tvalid, 0);
      check("pend_busy_hold", cfg_pending, 1);
      check("pend_busy_bits", rx_data_bits, 2'b00);
      rx_busy = 1'b0;
      tick();
      check("pend_new_bits", rx_data_bits, 2'b01);
      check("pend_new_par", rx_parity_en, 1);
      check("pend_clear", cfg_pending, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
